// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the WISC control pipeline.
package ctrl_pkg;

  localparam int RD_W = 4;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLB = 4'hA;
  localparam logic [3:0] OP_LHB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef struct packed {
    logic            valid;
    logic            alusrc;
    logic            memread;
    logic            memwrite;
    logic            loadbyte;
    logic            memtoreg;
    logic            regwrite;
    logic            is_hlt;
    logic [RD_W-1:0] rd;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    valid:    1'b0,
    alusrc:   1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    loadbyte: 1'b0,
    memtoreg: 1'b0,
    regwrite: 1'b0,
    is_hlt:   1'b0,
    rd:       {RD_W{1'b0}}
  };

  // A source operand conflicts only when the instruction actually reads it.
  function automatic logic src_hit(input logic used, input logic [RD_W-1:0] src,
                                   input logic [RD_W-1:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode into ctrl_t plus source-register-use flags.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int REG_W   = RD_W
) (
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               valid_i,
  output ctrl_t              ctrl_o,
  output logic               use_rs_o,
  output logic               use_rt_o,
  output logic               use_rd_o
);

  logic [3:0] op_s;

  assign op_s = instr_i[INSTR_W-1 -: 4];

  // Control bits and source usage; everything stays zero for a bubble.
  always_comb begin
    ctrl_o   = CTRL_BUBBLE;
    use_rs_o = 1'b0;
    use_rt_o = 1'b0;
    use_rd_o = 1'b0;
    if (valid_i) begin
      ctrl_o.valid    = 1'b1;
      ctrl_o.memread  = (op_s == OP_LW);
      ctrl_o.memwrite = (op_s == OP_SW);
      ctrl_o.loadbyte = (op_s == OP_LLB) || (op_s == OP_LHB);
      ctrl_o.memtoreg = (op_s == OP_LW);
      ctrl_o.alusrc   = (op_s inside {4'h4, 4'h5, 4'h6, OP_LW, OP_SW});
      ctrl_o.regwrite = !(op_s inside {OP_SW, OP_B, OP_BR, OP_HLT});
      ctrl_o.is_hlt   = (op_s == OP_HLT);
      ctrl_o.rd       = instr_i[3*REG_W-1 -: REG_W];
      case (op_s)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
          use_rs_o = 1'b1;
          use_rt_o = 1'b1;
        end
        OP_LW: use_rs_o = 1'b1;
        OP_SW: begin
          use_rs_o = 1'b1;
          use_rd_o = 1'b1;
        end
        OP_LLB, OP_LHB: use_rd_o = 1'b1;
        default: begin
          use_rs_o = 1'b0;
          use_rt_o = 1'b0;
          use_rd_o = 1'b0;
        end
      endcase
    end else begin
      ctrl_o = CTRL_BUBBLE;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// WISC control pipeline: ID decode, ID/EX, EX/MEM, MEM/WB stage registers,
// load-use stall, flush and sticky halt. Optional CTRL_PERF_CNT_EN adds counters.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int INSTR_W    = 16,
  parameter int REG_W      = RD_W,
  parameter int MEM_STAGES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               id_valid,
  input  logic               stall_ext,
  input  logic               flush,
  output logic               stall_req,
  output logic               ex_alusrc,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_loadbyte,
  output logic [REG_W-1:0]   ex_rd,
  output logic               mem_memread,
  output logic               mem_memwrite,
  output logic               wb_regwrite,
  output logic               wb_memtoreg,
  output logic [REG_W-1:0]   wb_rd,
  output logic               halted
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cycles,
  output logic [15:0]        flush_cycles
`endif
);

  localparam int LAST = MEM_STAGES - 1;

  ctrl_t id_ctrl_s;
  logic  use_rs_s, use_rt_s, use_rd_s;
  logic  stall_req_s;
  logic  ex_v_s, mem_v_s, wb_v_s;

  ctrl_t idex_q, idex_d;
  ctrl_t exmem_q, exmem_d;
  ctrl_t memwb_q [MEM_STAGES];
  ctrl_t memwb_d [MEM_STAGES];
  logic  halted_q, halted_d;

  ctrl_decode #(.INSTR_W(INSTR_W), .REG_W(REG_W)) u_decode (
    .instr_i  (id_instr),
    .valid_i  (id_valid),
    .ctrl_o   (id_ctrl_s),
    .use_rs_o (use_rs_s),
    .use_rt_o (use_rt_s),
    .use_rd_o (use_rd_s)
  );

  // Load-use hazard: a load in EX whose destination feeds the ID instruction.
  assign stall_req_s = !halted_q && idex_q.valid && idex_q.memread &&
                       (src_hit(use_rs_s, id_instr[2*REG_W-1 -: REG_W], idex_q.rd) ||
                        src_hit(use_rt_s, id_instr[REG_W-1:0], idex_q.rd) ||
                        src_hit(use_rd_s, id_instr[3*REG_W-1 -: REG_W], idex_q.rd));

  // Stage advance with halt > stall_ext > flush > load-use stall priority.
  always_comb begin
    idex_d   = idex_q;
    exmem_d  = exmem_q;
    memwb_d  = memwb_q;
    halted_d = halted_q;
    if (halted_q) begin
      idex_d  = CTRL_BUBBLE;
      exmem_d = CTRL_BUBBLE;
      for (int i = 0; i < MEM_STAGES; i++) begin
        memwb_d[i] = CTRL_BUBBLE;
      end
    end else if (stall_ext) begin
      halted_d = halted_q;
    end else begin
      halted_d = memwb_q[LAST].valid && memwb_q[LAST].is_hlt;
      if (flush || stall_req_s) begin
        idex_d = CTRL_BUBBLE;
      end else begin
        idex_d = id_ctrl_s;
      end
      exmem_d    = idex_q;
      memwb_d[0] = exmem_q;
      for (int i = 1; i < MEM_STAGES; i++) begin
        memwb_d[i] = memwb_q[i-1];
      end
    end
  end

  // Stage and halt registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q   <= CTRL_BUBBLE;
      exmem_q  <= CTRL_BUBBLE;
      halted_q <= 1'b0;
      for (int i = 0; i < MEM_STAGES; i++) begin
        memwb_q[i] <= CTRL_BUBBLE;
      end
    end else begin
      idex_q   <= idex_d;
      exmem_q  <= exmem_d;
      memwb_q  <= memwb_d;
      halted_q <= halted_d;
    end
  end

  // A halted core drives no control, even for instructions still in flight.
  assign ex_v_s  = idex_q.valid && !halted_q;
  assign mem_v_s = exmem_q.valid && !halted_q;
  assign wb_v_s  = memwb_q[LAST].valid && !halted_q;

  assign stall_req    = stall_req_s;
  assign ex_alusrc    = ex_v_s && idex_q.alusrc;
  assign ex_memread   = ex_v_s && idex_q.memread;
  assign ex_memwrite  = ex_v_s && idex_q.memwrite;
  assign ex_loadbyte  = ex_v_s && idex_q.loadbyte;
  assign ex_rd        = ex_v_s ? idex_q.rd : {REG_W{1'b0}};
  assign mem_memread  = mem_v_s && exmem_q.memread;
  assign mem_memwrite = mem_v_s && exmem_q.memwrite;
  assign wb_regwrite  = wb_v_s && memwb_q[LAST].regwrite;
  assign wb_memtoreg  = wb_v_s && memwb_q[LAST].memtoreg;
  assign wb_rd        = wb_v_s ? memwb_q[LAST].rd : {REG_W{1'b0}};
  assign halted       = halted_q;

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        stall_take_s, flush_take_s;

  // A stall only counts when it actually inserted the bubble (flush wins).
  assign stall_take_s = stall_req_s && !flush && !stall_ext && !halted_q;
  assign flush_take_s = flush && !stall_ext && !halted_q;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_take_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_take_s && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule
